// File: rtl/dmem_access_sequencer.sv
// Data-memory access sequencer: turns MEM-stage load/store/fence controls into a
// single-outstanding valid/ready request, stalls the pipeline and extends load data.
module dmem_access_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        fence,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        fence_req,
  input  logic        fence_ack
);

  // state    | meaning
  // IDLE     | waiting for a memory op or fence from the MEM stage
  // REQ      | request presented, waiting for req_ready
  // WAIT_RSP | read accepted, waiting for rsp_valid
  // FENCE    | fence_req raised, waiting for fence_ack
  // DONE     | one-cycle completion pulse, pipeline released
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_FENCE,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        mis_q;

  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;
  logic [31:0] lane;
  logic [31:0] ext_data;

  assign mem_op   = mem_read | mem_write;
  assign is_half  = (funct3[1:0] == 2'b01);
  assign is_word  = funct3[1];
  assign misalign = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));

  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc   = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc   = 4'b0011 << addr[1:0];
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Lane select then extend; word loads are aligned so the shift is zero.
  assign lane = rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ext_data = lane;
    case (f3_q)
      3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_data = {24'h0, lane[7:0]};
      3'b101:  ext_data = {16'h0, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (mem_op)     state_nxt = misalign ? S_DONE : S_REQ;
        else if (fence) state_nxt = S_FENCE;
      end
      S_REQ:      if (req_ready) state_nxt = req_we ? S_DONE : S_WAIT_RSP;
      S_WAIT_RSP: if (rsp_valid) state_nxt = S_DONE;
      S_FENCE:    if (fence_ack) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_addr  <= 32'h0;
      req_be    <= 4'h0;
      req_wdata <= 32'h0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      mis_q     <= 1'b0;
      load_data <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            mis_q <= misalign;
            if (!misalign) begin
              req_we    <= mem_write & ~mem_read;
              req_addr  <= {addr[31:2], 2'b00};
              req_be    <= be_calc;
              req_wdata <= wdata_rep;
              off_q     <= addr[1:0];
              f3_q      <= funct3;
            end
            if (!mem_read || misalign) load_data <= 32'h0;
          end else if (fence) begin
            mis_q     <= 1'b0;
            load_data <= 32'h0;
          end
        end
        S_WAIT_RSP: if (rsp_valid) load_data <= ext_data;
        S_DONE:     mis_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_valid  = (state == S_REQ);
  assign fence_req  = (state == S_FENCE);
  assign done       = (state == S_DONE);
  assign misaligned = done & mis_q;
  assign stall      = ((state != S_IDLE) && (state != S_DONE)) ||
                      ((state == S_IDLE) && (mem_read | mem_write | fence));

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Scoreboard bench for dmem_access_sequencer: each operation pushes its expected
// request fields and result, popped and compared when done pulses.
module tb_dmem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, fence;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned;
  logic [31:0] load_data;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        fence_req, fence_ack;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        mis;
    logic        has_req;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_access_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .fence(fence),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fence_req(fence_req), .fence_ack(fence_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.we      = mw & ~mr;
    e.addr    = {a[31:2], 2'b00};
    e.mis     = 1'b0;
    e.has_req = mr | mw;
    e.ld      = 32'h0;
    case (a[1:0])
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000, 3'b100: begin e.be = 4'b0001 << a[1:0]; e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      3'b001, 3'b101: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {wd[15:0], wd[15:0]};
                            e.mis = a[0]; end
      default:        begin e.be = 4'b1111; e.wdata = wd; e.mis = (a[1:0] != 2'b00); end
    endcase
    if (!(mr | mw)) e.mis = 1'b0;
    if (e.mis) e.has_req = 1'b0;
    if (mr && !e.mis) begin
      case (f3)
        3'b000:  e.ld = {{24{b[7]}}, b};
        3'b001:  e.ld = {{16{h[15]}}, h};
        3'b100:  e.ld = {24'h0, b};
        3'b101:  e.ld = {16'h0, h};
        default: e.ld = rd;
      endcase
    end
    return e;
  endfunction

  // Called just after a falling edge; returns just after a later falling edge.
  task automatic run_op(input string tag, input logic mr, input logic mw, input logic fn,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ready_dly, input int ack_dly,
                        input int exp_stall);
    exp_t e, cur;
    int   stalls = 0, wcnt = 0, fcnt = 0, cyc = 0;
    bit   pend = 0, saw_req = 0, fin = 0;
    e = model(mr, mw, f3, a, wd, rd);
    sb_q.push_back(e);
    mem_read = mr; mem_write = mw; fence = fn;
    funct3 = f3; addr = a; wdata = wd; rsp_rdata = rd;
    while (!fin && cyc < 100) begin
      #1;
      if (done) begin
        cur = sb_q.pop_front();
        check_val({tag, " load_data"}, load_data, cur.ld);
        check_val({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, cur.mis});
        check_val({tag, " req_seen"}, {31'h0, saw_req}, {31'h0, cur.has_req});
        check_val({tag, " stall_cycles"}, stalls, exp_stall);
        check_val({tag, " done_stall"}, {31'h0, stall}, 32'h0);
        check_val({tag, " done_fence_req"}, {31'h0, fence_req}, 32'h0);
        mem_read = 0; mem_write = 0; fence = 0;
        req_ready = 0; rsp_valid = 0; fence_ack = 0;
        fin = 1;
      end else begin
        if (stall) stalls++;
        rsp_valid = pend;
        pend = 0;
        if (req_valid) begin
          saw_req = 1;
          check_val({tag, " req_we"}, {31'h0, req_we}, {31'h0, sb_q[0].we});
          check_val({tag, " req_addr"}, req_addr, sb_q[0].addr);
          check_val({tag, " req_be"}, {28'h0, req_be}, {28'h0, sb_q[0].be});
          if (sb_q[0].we) check_val({tag, " req_wdata"}, req_wdata, sb_q[0].wdata);
          req_ready = (wcnt >= ready_dly);
          wcnt++;
          if (req_ready && !req_we) pend = 1;
        end else begin
          req_ready = 0;
        end
        fence_ack = fence_req && (fcnt >= ack_dly);
        if (fence_req) fcnt++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) begin
      check_val({tag, " timeout"}, 32'h0, 32'h1);
      mem_read = 0; mem_write = 0; fence = 0;
      req_ready = 0; rsp_valid = 0; fence_ack = 0;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    @(negedge clk);
    #1;
    check_val({tag, " done_pulse"}, {31'h0, done}, 32'h0);
    check_val({tag, " idle_stall"}, {31'h0, stall}, 32'h0);
  endtask

  initial begin
    rst_n = 0;
    mem_read = 0; mem_write = 0; fence = 0; funct3 = 0; addr = 0; wdata = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0; fence_ack = 0;
    #1;
    check_val("rst req_valid", {31'h0, req_valid}, 32'h0);
    check_val("rst stall", {31'h0, stall}, 32'h0);
    check_val("rst done", {31'h0, done}, 32'h0);
    check_val("rst load_data", load_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;

    //      tag      mr mw fn f3      addr          wdata         rdata       rdy ack stl
    run_op("SW",     0, 1, 0, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        0, 0, 2);
    run_op("LB",     1, 0, 0, 3'b000, 32'h0000_0203, 32'h0,        32'h80123456, 0, 0, 3);
    run_op("LBU",    1, 0, 0, 3'b100, 32'h0000_0203, 32'h0,        32'h80123456, 0, 0, 3);
    run_op("LHU",    1, 0, 0, 3'b101, 32'h0000_0202, 32'h0,        32'h80123456, 0, 0, 3);
    run_op("LH",     1, 0, 0, 3'b001, 32'h0000_0202, 32'h0,        32'h80123456, 0, 0, 3);
    run_op("LB0",    1, 0, 0, 3'b000, 32'h0000_0300, 32'h0,        32'h000000F1, 2, 0, 5);
    run_op("SH",     0, 1, 0, 3'b001, 32'h0000_0012, 32'h0000ABCD, 32'h0,        5, 0, 7);
    run_op("SB",     0, 1, 0, 3'b000, 32'h0000_0101, 32'h11223377, 32'h0,        0, 0, 2);
    run_op("LW",     1, 0, 0, 3'b010, 32'h0000_0104, 32'h0,        32'h12345678, 0, 0, 3);
    run_op("LW_mis", 1, 0, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h12345678, 0, 0, 1);
    run_op("LH",     1, 0, 0, 3'b001, 32'h0000_0400, 32'h0,        32'h0000F00D, 0, 0, 3);
    run_op("SH_mis", 0, 1, 0, 3'b001, 32'h0000_0203, 32'h0000ABCD, 32'h0,        0, 0, 1);
    run_op("FENCE",  0, 0, 1, 3'b000, 32'h0,         32'h0,        32'h0,        0, 3, 5);
    run_op("RD_WR",  1, 1, 0, 3'b010, 32'h0000_0800, 32'h55555555, 32'hA5A5A5A5, 0, 0, 3);
    run_op("OP_FEN", 1, 0, 1, 3'b010, 32'h0000_0900, 32'h0,        32'hCAFEF00D, 0, 0, 3);

    // Reset while waiting for read data.
    mem_read = 1; funct3 = 3'b010; addr = 32'h0000_0040;
    @(negedge clk); #1;
    check_val("rst_seq req_valid", {31'h0, req_valid}, 32'h1);
    req_ready = 1;
    @(negedge clk); #1;
    req_ready = 0; mem_read = 0;
    check_val("rst_seq wait_stall", {31'h0, stall}, 32'h1);
    rst_n = 0;
    #1;
    check_val("rst_async stall", {31'h0, stall}, 32'h0);
    check_val("rst_async req_addr", req_addr, 32'h0);
    check_val("rst_async req_be", {28'h0, req_be}, 32'h0);
    check_val("rst_async req_wdata", req_wdata, 32'h0);
    check_val("rst_async load_data", load_data, 32'h0);
    check_val("rst_async req_valid", {31'h0, req_valid}, 32'h0);
    check_val("rst_async done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    rsp_valid = 1; rsp_rdata = 32'h77777777;
    @(negedge clk); #1;
    rsp_valid = 0;
    check_val("stray done", {31'h0, done}, 32'h0);
    check_val("stray load_data", load_data, 32'h0);
    check_val("stray stall", {31'h0, stall}, 32'h0);
    @(negedge clk); #1;
    run_op("SW_post", 0, 1, 0, 3'b010, 32'h0000_0044, 32'h01020304, 32'h0, 1, 0, 3);

    check_val("sb_empty", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
